uio_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 8-bit bidirectional uio pad bus of the tile top level. It grants the bus to one of NREQ internal requesters at a time, drives `uio_out`/`uio_oe` on the owner's behalf, captures input data for reading owners, and inserts a guaranteed tri-state turnaround between owners. It sits between the internal functional units and the top-level `uio_in`/`uio_out`/`uio_oe` pins.

---
 rtl/uio_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit uio pad bus with tri-state turnaround between owners.
// Optional hold timeout with preemption is enabled by defining UIO_ARB_TIMEOUT_EN.
module uio_bus_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_dir,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              preempt,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int unsigned OwW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  typedef enum logic [1:0] {StIdle, StTurn, StOwn} state_e;

  state_e         state_q, state_d;
  logic [OwW-1:0] owner_q, owner_d;
  logic [OwW-1:0] last_q, last_d;
  logic [OwW-1:0] winner;
  logic           found;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           timeout;
  logic           own_dir;

  assign own_dir = req_dir[owner_q];

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      if (!found && req[(int'(last_q) + i) % int'(NREQ)]) begin
        winner = OwW'((int'(last_q) + i) % int'(NREQ));
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ena && found) begin
          owner_d = winner;
          cnt_d   = 3'(TURNAROUND);
          state_d = StTurn;
        end
      end
      StTurn: begin
        if (!ena) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StOwn;
        end
      end
      StOwn: begin
        if (!ena) begin
          state_d = StIdle;
        end else if (!req[owner_q] || timeout) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant   = '0;
    uio_oe  = '0;
    uio_out = '0;
    if (state_q == StOwn) begin
      grant[owner_q] = 1'b1;
      uio_oe         = {8{own_dir}};
      if (own_dir) uio_out = req_data[{owner_q, 3'b000} +: 8];
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    if (state_q == StOwn && !own_dir) rd_data_d = uio_in;
    // Valid only while ownership continues, so it drops together with grant on release.
    rd_valid_d = (state_q == StOwn) && (state_d == StOwn) && !own_dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      last_q     <= OwW'(NREQ - 1);
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0]      hold_q, hold_d;
  logic            preempt_q;
  logic [NREQ-1:0] others;

  // Hold count saturates so a lone owner that overstays is preempted once a competitor shows up.
  always_comb begin
    others          = req;
    others[owner_q] = 1'b0;
    hold_d          = 8'd0;
    if (state_q == StOwn) hold_d = (hold_q == MaxHold) ? hold_q : hold_q + 8'd1;
    timeout = (state_q == StOwn) && ena && req[owner_q] && (hold_d == MaxHold) && (|others);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= timeout;
    end
  end

  assign preempt = preempt_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MaxHold;
  assign timeout         = 1'b0;
  assign preempt         = 1'b0;
`endif

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed self-checking bench for uio_bus_arbiter (NREQ=4, TURNAROUND=1, MAX_HOLD=4).
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_dir = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        preempt;
  logic [7:0]  uio_in = '0;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int n_checks = 0;
  int n_errors = 0;
  int pend = -1;
  int since = 0;

  uio_bus_arbiter #(
    .NREQ      (4),
    .TURNAROUND(1),
    .MAX_HOLD  (4)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .req_dir (req_dir),
    .req_data(req_data),
    .grant   (grant),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .preempt (preempt),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick that also re-raises a dropped round-robin requester two cycles after it let go.
  task automatic tick_rr();
    tick();
    if (pend >= 0) begin
      since++;
      if (since == 2) begin
        req[pend] = 1'b1;
        pend = -1;
      end
    end
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int         gap;
    logic [3:0] expg;
    logic       seen;

    // Reset state
    #2;
    check("rst_grant", grant, 0);
    check("rst_oe", uio_oe, 0);
    check("rst_out", uio_out, 0);
    check("rst_rd", {rd_valid, rd_data}, 0);
    check("rst_preempt", preempt, 0);
    #10;
    rst_n = 1'b1;
    ena   = 1'b1;

    // Single driver
    tick();
    req_dir  = 4'b0001;
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    tick();
    check("lat_turn", {uio_oe, grant}, 0);
    tick();
    check("drv_grant", grant, 4'b0001);
    check("drv_oe", uio_oe, 8'hFF);
    check("drv_out", uio_out, 8'hA5);
    req = 4'b0000;
    tick();
    check("drv_release", {uio_oe, grant}, 0);

    // Round robin, order 0,1,2,3,0
    do_reset();
    req_dir  = 4'hF;
    req_data = 32'hC3C2_C1C0;
    req      = 4'hF;
    for (int g = 0; g < 5; g++) begin
      expg = 4'b0001 << (g % 4);
      gap  = 0;
      tick_rr();
      while (grant == 4'd0 && gap < 8) begin
        gap++;
        tick_rr();
      end
      check("rr_owner", grant, expg);
      check("rr_gap", gap, (g == 0) ? 1 : 2);
      check("rr_data", uio_out, 8'hC0 + 8'(g % 4));
      tick_rr();
      tick_rr();
      check("rr_hold", grant, expg);
      req[g % 4] = 1'b0;
      pend  = g % 4;
      since = 0;
    end
    tick();
    tick();
    pend = -1;

    // Reader on requester 2
    do_reset();
    req_dir = 4'b0000;
    req     = 4'b0100;
    tick();
    tick();
    check("rd_grant", grant, 4'b0100);
    check("rd_oe", uio_oe, 0);
    check("rd_first_valid", rd_valid, 0);
    for (int i = 0; i < 3; i++) begin
      uio_in = 8'h10 + 8'(i);
      tick();
      check("rd_data", {rd_valid, rd_data}, {1'b1, 8'h10 + 8'(i)});
    end
    req = 4'b0000;
    tick();
    check("rd_release", {rd_valid, grant}, 0);

    // Asynchronous reset mid-OWN
    req_dir  = 4'hF;
    req_data = 32'h0000_005A;
    req      = 4'b0001;
    tick();
    tick();
    check("ar_own", {uio_oe, grant}, {8'hFF, 4'b0001});
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async", {uio_oe, grant}, 0);
    #1;
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    tick();
    check("ar_first_win", grant, 4'b0001);

    // ena drop during requester 1 ownership
    req = 4'b0010;
    tick();
    tick();
    tick();
    check("en_own1", grant, 4'b0010);
    req = 4'b1010;
    ena = 1'b0;
    tick();
    check("en_idle", {uio_oe, grant}, 0);
    tick();
    tick();
    tick();
    check("en_blocked", grant, 0);
    ena = 1'b1;
    tick();
    tick();
    check("en_regrant", grant, 4'b0010);

    // Hold timeout behaviour
    do_reset();
    req = 4'b0011;
    tick();
    tick();
    check("to_own0", grant, 4'b0001);
`ifdef UIO_ARB_TIMEOUT_EN
    tick();
    tick();
    tick();
    check("to_hold4", {preempt, grant}, {1'b0, 4'b0001});
    tick();
    check("to_preempt", {preempt, grant}, {1'b1, 4'b0000});
    tick();
    check("to_pulse_end", {preempt, grant}, 0);
    tick();
    check("to_grant1", grant, 4'b0010);
`else
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | preempt | (grant != 4'b0001);
    end
    check("to_no_preempt", seen, 0);
    check("to_still0", grant, 4'b0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
